seg_display_scan: RTL and testbench

Time display stage that consumes the timer/set register outputs (`hour_data`, `minute_data`, `second_data`, `mode`, `minute_set`, `hour_set`) and drives a 6-digit multiplexed 7-segment display. Each field is converted to two BCD digits and one digit is scanned at a time. Inputs are snapshotted once per frame so a digit never tears mid-scan. In set mode, the field being adjusted blinks.

---
 rtl/seg_display_scan.sv | 164 ++++++++++++++++
 tb/tb_seg_display_scan.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_scan.sv
// seg_display_scan: six-digit multiplexed 7-segment time display.
// Shows hours, minutes and seconds as BCD digit pairs, one digit at a time.
// Data inputs are captured once per frame, so a frame never mixes old and new values.
// In set mode, the field being adjusted blinks.
module seg_display_scan #(
  parameter int scan_cnt  = 1000,
  parameter int blink_cnt = 250000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       minute_set,
  input  logic       hour_set,
  input  logic [5:0] hour_data,
  input  logic [5:0] minute_data,
  input  logic [5:0] second_data,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] digit_sel
);

  localparam int SCNT_W = $clog2(scan_cnt);
  localparam int BCNT_W = $clog2(blink_cnt);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(scan_cnt - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(blink_cnt - 1);
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  logic [SCNT_W-1:0] scnt_q, scnt_d;
  logic [2:0]        digit_idx_q, digit_idx_d;
  logic              frame_wrap;
  logic [BCNT_W-1:0] bcnt_q, bcnt_d;
  logic              blink_phase_q, blink_phase_d;
  logic [5:0]        hour_snap_q, hour_snap_d;
  logic [5:0]        minute_snap_q, minute_snap_d;
  logic [5:0]        second_snap_q, second_snap_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic [5:0]        digit_sel_q, digit_sel_d;

  logic [5:0] field_val;
  logic [5:0] bcd_tens;
  logic [5:0] bcd_ones;
  logic [6:0] digit_code;
  logic       blank;

  // Encode a single decimal digit. Out-of-range values never reach this,
  // because they are caught by the >= 60 dash check.
  function automatic logic [6:0] seg7(input logic [5:0] v);
    case (v)
      6'd0:    seg7 = 7'h3F;
      6'd1:    seg7 = 7'h06;
      6'd2:    seg7 = 7'h5B;
      6'd3:    seg7 = 7'h4F;
      6'd4:    seg7 = 7'h66;
      6'd5:    seg7 = 7'h6D;
      6'd6:    seg7 = 7'h7D;
      6'd7:    seg7 = 7'h07;
      6'd8:    seg7 = 7'h7F;
      6'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction

  // Scan timing: dwell counter and digit index; flag the frame wrap (5 -> 0).
  always_comb begin
    scnt_d      = scnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    frame_wrap  = 1'b0;
    if (scnt_q == SCNT_LAST) begin
      scnt_d = '0;
      if (digit_idx_q == 3'd5) begin
        digit_idx_d = 3'd0;
        frame_wrap  = 1'b1;
      end else begin
        digit_idx_d = digit_idx_q + 3'd1;
      end
    end
  end

  // Frame snapshot: capture all fields together at the frame wrap only.
  always_comb begin
    hour_snap_d   = hour_snap_q;
    minute_snap_d = minute_snap_q;
    second_snap_d = second_snap_q;
    if (frame_wrap) begin
      hour_snap_d   = hour_data;
      minute_snap_d = minute_data;
      second_snap_d = second_data;
    end
  end

  // Blink timebase. It is held cleared in timer mode, so set mode always starts visible.
  always_comb begin
    bcnt_d        = '0;
    blink_phase_d = 1'b0;
    if (!mode) begin
      if (bcnt_q == BCNT_LAST) begin
        bcnt_d        = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        bcnt_d        = bcnt_q + 1'b1;
        blink_phase_d = blink_phase_q;
      end
    end
  end

  // Digit content: pick the field, convert it to BCD, apply dash and blanking,
  // and form the next registered outputs.
  always_comb begin
    case (digit_idx_q)
      3'd0, 3'd1: field_val = hour_snap_q;
      3'd2, 3'd3: field_val = minute_snap_q;
      default:    field_val = second_snap_q;
    endcase
    bcd_tens = field_val / 6'd10;
    bcd_ones = field_val % 6'd10;
    if (field_val >= 6'd60) begin
      digit_code = SEG_DASH;
    end else if (!digit_idx_q[0]) begin
      digit_code = seg7(bcd_tens);
    end else begin
      digit_code = seg7(bcd_ones);
    end
    blank = !mode && blink_phase_q &&
            ((hour_set   && (digit_idx_q == 3'd0 || digit_idx_q == 3'd1)) ||
             (minute_set && (digit_idx_q == 3'd2 || digit_idx_q == 3'd3)));
    seg_d       = blank ? SEG_BLANK : digit_code;
    dp_d        = (digit_idx_q == 3'd1) || (digit_idx_q == 3'd3);
    digit_sel_d = ~(6'b000001 << digit_idx_q);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      scnt_q        <= '0;
      digit_idx_q   <= 3'd0;
      bcnt_q        <= '0;
      blink_phase_q <= 1'b0;
      hour_snap_q   <= 6'd0;
      minute_snap_q <= 6'd0;
      second_snap_q <= 6'd0;
      seg_q         <= SEG_BLANK;
      dp_q          <= 1'b0;
      digit_sel_q   <= 6'b111111;
    end else begin
      scnt_q        <= scnt_d;
      digit_idx_q   <= digit_idx_d;
      bcnt_q        <= bcnt_d;
      blink_phase_q <= blink_phase_d;
      hour_snap_q   <= hour_snap_d;
      minute_snap_q <= minute_snap_d;
      second_snap_q <= second_snap_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      digit_sel_q   <= digit_sel_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign digit_sel = digit_sel_q;

endmodule

// File: tb/tb_seg_display_scan.sv
// Testbench for seg_display_scan with scan_cnt=4 and blink_cnt=8.
module tb_seg_display_scan;

  localparam int SCAN  = 4;
  localparam int BLINK = 8;

  // Expected segment codes for one frame, stored as index d -> digit d.
  typedef logic [5:0][6:0] frame_t;
  typedef struct {
    logic [5:0] h;
    logic [5:0] m;
    logic [5:0] s;
    frame_t     ex;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic       minute_set;
  logic       hour_set;
  logic [5:0] hour_data;
  logic [5:0] minute_data;
  logic [5:0] second_data;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] digit_sel;

  int total = 0;
  int bad   = 0;

  vec_t   vecs [6];
  frame_t zeros_f;
  frame_t f_123556;

  always #5 clock = ~clock;

  seg_display_scan #(.scan_cnt(SCAN), .blink_cnt(BLINK)) dut (
    .clock       (clock),
    .reset       (reset),
    .mode        (mode),
    .minute_set  (minute_set),
    .hour_set    (hour_set),
    .hour_data   (hour_data),
    .minute_data (minute_data),
    .second_data (second_data),
    .seg         (seg),
    .dp          (dp),
    .digit_sel   (digit_sel)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance until the first cycle of a d0 output; the wait is bounded.
  task automatic wait_frame_start();
    logic [5:0] prev;
    int n;
    n = 0;
    do begin
      prev = digit_sel;
      step();
      n++;
    end while (!(digit_sel == 6'b111110 && prev != 6'b111110) && n < 60);
    if (n >= 60) begin
      total++;
      bad++;
      $display("FAIL frame_sync: digit_sel=%b, no d0 start within 60 clocks", digit_sel);
    end
  endtask

  // Check one full frame, assuming the current sample is the first cycle of d0.
  task automatic check_frame(input frame_t ex, input string tag);
    logic [5:0] es;
    for (int d = 0; d < 6; d++) begin
      for (int c = 0; c < SCAN; c++) begin
        if (!(d == 0 && c == 0)) step();
        es = ~(6'b000001 << d);
        chk($sformatf("%s d%0d c%0d sel", tag, d, c), 7'(digit_sel), 7'(es));
        chk($sformatf("%s d%0d c%0d seg", tag, d, c), seg, ex[d]);
        chk($sformatf("%s d%0d c%0d dp", tag, d, c), 7'(dp), 7'((d == 1 || d == 3) ? 1'b1 : 1'b0));
      end
    end
  endtask

  // Run set mode from frame offset p0 for n clocks, then go back to timer mode
  // before clock back_k. Precondition: timer mode, so the blink timebase is cleared.
  task automatic blink_run(input int p0, input int n, input int back_k,
                           input logic ms, input logic hs, input frame_t ex, input string tag);
    int p;
    int d;
    logic blank;
    logic [5:0] es;
    wait_frame_start();
    repeat (p0) step();
    mode = 1'b0;
    minute_set = ms;
    hour_set = hs;
    for (int k = 1; k <= n; k++) begin
      if (k == back_k) mode = 1'b1;
      step();
      p = (p0 + k) % (6 * SCAN);
      d = p / SCAN;
      blank = (k < back_k) && ((((k - 1) / BLINK) % 2) == 1) &&
              ((hs && d <= 1) || (ms && (d == 2 || d == 3)));
      es = ~(6'b000001 << d);
      chk($sformatf("%s k%0d sel", tag, k), 7'(digit_sel), 7'(es));
      chk($sformatf("%s k%0d seg", tag, k), seg, blank ? 7'h00 : ex[d]);
    end
    mode = 1'b1;
    minute_set = 1'b0;
    hour_set = 1'b0;
    $display("blink %s: done, total=%0d bad=%0d", tag, total, bad);
  endtask

  initial begin
    // Expected frames are written as {d5, d4, d3, d2, d1, d0}.
    zeros_f  = {7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    f_123556 = {7'h7D, 7'h6D, 7'h6D, 7'h4F, 7'h5B, 7'h06};
    vecs[0] = '{h: 6'd0,  m: 6'd0,  s: 6'd63, ex: {7'h40, 7'h40, 7'h3F, 7'h3F, 7'h3F, 7'h3F}};
    vecs[1] = '{h: 6'd23, m: 6'd59, s: 6'd0,  ex: {7'h3F, 7'h3F, 7'h6F, 7'h6D, 7'h4F, 7'h5B}};
    vecs[2] = '{h: 6'd60, m: 6'd7,  s: 6'd45, ex: {7'h6D, 7'h66, 7'h07, 7'h3F, 7'h40, 7'h40}};
    vecs[3] = '{h: 6'd59, m: 6'd10, s: 6'd38, ex: {7'h7F, 7'h4F, 7'h3F, 7'h06, 7'h6F, 7'h6D}};
    vecs[4] = '{h: 6'd24, m: 6'd8,  s: 6'd19, ex: {7'h6F, 7'h06, 7'h7F, 7'h3F, 7'h66, 7'h5B}};
    vecs[5] = '{h: 6'd12, m: 6'd34, s: 6'd56, ex: {7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06}};

    reset = 1'b0;
    mode = 1'b1;
    minute_set = 1'b0;
    hour_set = 1'b0;
    hour_data = 6'd12;
    minute_data = 6'd34;
    second_data = 6'd56;

    // Reset hold
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("rst%0d sel", i), 7'(digit_sel), 7'(6'b111111));
      chk($sformatf("rst%0d seg", i), seg, 7'h00);
      chk($sformatf("rst%0d dp", i), 7'(dp), 7'(1'b0));
    end
    $display("reset hold: total=%0d bad=%0d", total, bad);

    // First edge after release shows d0 of the all-zero snapshot; the whole first frame is zeros
    reset = 1'b1;
    step();
    check_frame(zeros_f, "first");
    $display("first frame: total=%0d bad=%0d", total, bad);

    // Table of static values
    for (int i = 0; i < 6; i++) begin
      hour_data = vecs[i].h;
      minute_data = vecs[i].m;
      second_data = vecs[i].s;
      wait_frame_start();
      wait_frame_start();
      check_frame(vecs[i].ex, $sformatf("vec%0d", i));
      $display("vec %0d %0d:%0d:%0d checked, total=%0d bad=%0d",
               i, vecs[i].h, vecs[i].m, vecs[i].s, total, bad);
    end

    // Tear-free update: change minutes during d2
    wait_frame_start();
    repeat (2 * SCAN) step();
    minute_data = 6'd35;
    repeat (SCAN) step();
    chk("tear same-frame sel", 7'(digit_sel), 7'(6'b110111));
    chk("tear same-frame seg", seg, 7'h66);
    wait_frame_start();
    repeat (3 * SCAN) step();
    chk("tear next-frame sel", 7'(digit_sel), 7'(6'b110111));
    chk("tear next-frame seg", seg, 7'h6D);
    $display("tear-free: total=%0d bad=%0d", total, bad);

    // Blink tests; the snapshot now holds 12:35:56
    blink_run(0, 72, 59, 1'b1, 1'b0, f_123556, "minute");
    blink_run(16, 24, 1000, 1'b0, 1'b1, f_123556, "hour");
    blink_run(20, 24, 1000, 1'b1, 1'b1, f_123556, "both");

    // Reset mid-frame while d3 is selected
    wait_frame_start();
    repeat (3 * SCAN) step();
    reset = 1'b0;
    step();
    chk("midrst sel", 7'(digit_sel), 7'(6'b111111));
    chk("midrst seg", seg, 7'h00);
    chk("midrst dp", 7'(dp), 7'(1'b0));
    reset = 1'b1;
    step();
    check_frame(zeros_f, "post_midrst");
    $display("mid-frame reset: total=%0d bad=%0d", total, bad);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
